// File: rtl/rotating_register_if.sv
// Control/data bundle for rotating_register: load/start requests in, register
// contents and start/busy/done status out. The state field is a debug view.
interface rotating_register_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output data_in, load, start, dir, mode, amount,
    input  q, busy, done, state
  );

  modport slave (
    input  data_in, load, start, dir, mode, amount,
    output q, busy, done, state
  );
endinterface

// File: rtl/rotating_register.sv
// Shift/rotate register built from per-bit 2:1 mux cells, with a small
// controller that sequences multi-step shifts through IDLE/SHIFT/DONE.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

module rotating_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input logic              clock,
  input logic              reset,
  rotating_register_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic             latch_en;
  logic             load_en;
  logic             shift_en;
  logic             q_en;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             fill_right;
  logic             fill_left;

  // Handshake: start is accepted only in IDLE with load low; busy is high for
  // every cycle spent in SHIFT; done pulses for the single DONE cycle, after
  // which the next start can be accepted.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    latch_en = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          load_en = 1'b1;
        end else if (bus.start) begin
          latch_en = 1'b1;
          count_d  = bus.amount;
          state_d  = (bus.amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        count_d  = count_q - 1'b1;
        if (count_q == AMT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      q_r     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (latch_en) begin
        dir_q  <= bus.dir;
        mode_q <= bus.mode;
      end
      q_r <= q_next;
    end
  end

  // Bits shifted in at the ends; mode 11 falls through to rotate.
  always_comb begin
    fill_right = q_r[0];
    fill_left  = q_r[WIDTH-1];
    if (mode_q == 2'b01) begin
      fill_right = 1'b0;
      fill_left  = 1'b0;
    end else if (mode_q == 2'b10) begin
      fill_right = q_r[WIDTH-1];
      fill_left  = 1'b0;
    end
  end

  assign q_en = load_en | shift_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic right_src, left_src, stepped, loaded;
    if (i == WIDTH - 1) begin : g_msb
      assign right_src = fill_right;
    end else begin : g_upper
      assign right_src = q_r[i+1];
    end
    if (i == 0) begin : g_lsb
      assign left_src = fill_left;
    end else begin : g_lower
      assign left_src = q_r[i-1];
    end
    mux2to1 u_dir  (.a(right_src), .b(left_src),       .s(dir_q),   .y(stepped));
    mux2to1 u_load (.a(stepped),   .b(bus.data_in[i]), .s(load_en), .y(loaded));
    mux2to1 u_hold (.a(q_r[i]),    .b(loaded),         .s(q_en),    .y(q_next[i]));
  end

  assign bus.q     = q_r;
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);
  assign bus.state = state_q;
endmodule

// File: tb/tb_rotating_register.sv
// Self-checking bench for rotating_register: directed scenarios followed by
// randomized load/shift operations checked against an arithmetic shift model.
module tb_rotating_register;
  localparam int W     = 8;
  localparam int AMT_W = $clog2(W);

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [W-1:0] model;
  logic [W-1:0] exp_q[$];

  rotating_register_if #(.WIDTH(W), .AMT_W(AMT_W)) bus ();

  rotating_register #(.WIDTH(W), .AMT_W(AMT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-operation result of shifting v by n positions.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input logic d,
                                             input logic [1:0] m, input int n);
    logic [W-1:0]        r;
    logic signed [W-1:0] s;
    s = v;
    if (n == 0) return v;
    if (m == 2'b01)      r = d ? (v << n) : (v >> n);
    else if (m == 2'b10) r = d ? (v << n) : W'(s >>> n);
    else                 r = d ? ((v << n) | (v >> (W - n))) : ((v >> n) | (v << (W - n)));
    return r;
  endfunction

  // Driver tasks
  task automatic clear_inputs();
    bus.load    = 1'b0;
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.dir     = 1'b0;
    bus.mode    = 2'b00;
    bus.amount  = '0;
  endtask

  task automatic noise_inputs();
    bus.load    = 1'($urandom_range(0, 1));
    bus.start   = 1'($urandom_range(0, 1));
    bus.data_in = W'($urandom_range(0, 255));
    bus.dir     = 1'($urandom_range(0, 1));
    bus.mode    = 2'($urandom_range(0, 3));
    bus.amount  = AMT_W'($urandom_range(0, W - 1));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    bus.load    = 1'b1;
    bus.data_in = v;
    tick();
    clear_inputs();
    model = v;
    check("load_q", bus.q, v);
    check("load_busy", bus.busy, 1'b0);
  endtask

  task automatic do_op(input logic d, input logic [1:0] m, input int n, input bit noise);
    logic [W-1:0] base;
    logic [W-1:0] e;
    base = model;
    for (int i = 1; i <= n; i++) exp_q.push_back(ref_shift(base, d, m, i));
    bus.dir    = d;
    bus.mode   = m;
    bus.amount = AMT_W'(n);
    bus.start  = 1'b1;
    tick();
    clear_inputs();
    check("start_q", bus.q, base);
    check("start_busy", bus.busy, (n != 0));
    check("start_done", bus.done, (n == 0));
    for (int i = 1; i <= n; i++) begin
      if (noise) noise_inputs();
      tick();
      e = exp_q.pop_front();
      check($sformatf("step%0d_q", i), bus.q, e);
      check($sformatf("step%0d_busy", i), bus.busy, (i < n));
      check($sformatf("step%0d_done", i), bus.done, (i == n));
    end
    model = ref_shift(base, d, m, n);
    if (noise) noise_inputs();
    tick();
    clear_inputs();
    check("idle_done", bus.done, 1'b0);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_q", bus.q, model);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model  = '0;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("reset_q", bus.q, 0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    reset = 1'b0;

    do_load(8'hA5);
    do_op(1'b0, 2'b00, 3, 1'b0);
    check("rotr3_a5", bus.q, 8'hB4);

    do_load(8'h81);
    do_op(1'b1, 2'b00, 1, 1'b0);
    check("rotl1_81", bus.q, 8'h03);

    do_load(8'h90);
    do_op(1'b0, 2'b10, 2, 1'b0);
    check("asr2_90", bus.q, 8'hE4);
    do_load(8'h90);
    do_op(1'b0, 2'b01, 2, 1'b0);
    check("lsr2_90", bus.q, 8'h24);

    do_load(8'hFF);
    do_op(1'b1, 2'b01, 7, 1'b0);
    check("lsl7_ff", bus.q, 8'h80);
    do_op(1'b1, 2'b01, 0, 1'b0);
    check("amt0_q", bus.q, 8'h80);

    // Load and start together: load wins, no operation begins.
    bus.load    = 1'b1;
    bus.data_in = 8'h3C;
    bus.start   = 1'b1;
    bus.amount  = AMT_W'(3);
    tick();
    clear_inputs();
    model = 8'h3C;
    check("ldst_q", bus.q, 8'h3C);
    check("ldst_busy", bus.busy, 1'b0);
    tick();
    check("ldst_busy2", bus.busy, 1'b0);
    check("ldst_done2", bus.done, 1'b0);

    // Load attempted during SHIFT is ignored.
    bus.dir    = 1'b0;
    bus.mode   = 2'b00;
    bus.amount = AMT_W'(4);
    bus.start  = 1'b1;
    tick();
    clear_inputs();
    bus.load    = 1'b1;
    bus.data_in = 8'h11;
    tick();
    tick();
    clear_inputs();
    tick();
    tick();
    check("ignload_done", bus.done, 1'b1);
    check("ignload_q", bus.q, ref_shift(8'h3C, 1'b0, 2'b00, 4));
    tick();
    model = ref_shift(8'h3C, 1'b0, 2'b00, 4);

    // Reset in the middle of a shift.
    do_load(8'hF0);
    bus.dir    = 1'b0;
    bus.mode   = 2'b00;
    bus.amount = AMT_W'(5);
    bus.start  = 1'b1;
    tick();
    clear_inputs();
    tick();
    tick();
    check("midrst_q_pre", bus.q, ref_shift(8'hF0, 1'b0, 2'b00, 2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_q", bus.q, 0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    do_load(8'h5A);
    do_op(1'b1, 2'b11, 2, 1'b0);

    // Randomized operations with junk on inputs while the controller is busy.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) do_load(W'($urandom_range(0, 255)));
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom_range(0, W - 1), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rotating_register.md
# rotating_register

Parameterised shift/rotate register that consumes the team's 2-to-1 mux cells. One `mux2to1` instance per bit chooses between the parallel-load value and the shifted neighbour; a further per-bit mux level chooses direction. A small controller sequences multi-step shifts with a start/busy/done handshake. The block sits directly downstream of the mux stage and forms the datapath register for the upcoming rotate/shift lab.

## Interface
- `WIDTH`, 8, register width in bits (≥2)
- `AMT_W`, $clog2(WIDTH), width of the shift-amount field
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`
- `data_in`  in  WIDTH  parallel-load value
- `load`  in  1  parallel load request (honoured only in IDLE)
- `start`  in  1  begin a shift operation (honoured only in IDLE)
- `dir`  in  1  0 = right (toward bit 0), 1 = left
- `mode`  in  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 treated as rotate
- `amount`  in  AMT_W  number of single-bit steps, 0..WIDTH-1
- `q`  out  WIDTH  register contents
- `busy`  out  1  high while in SHIFT
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE, `q`=0, internal count=0, `busy`=0, `done`=0.
- Reset has priority over every other input, including in SHIFT and DONE. A reset mid-operation abandons the shift and returns to IDLE with `q`=0.
- IDLE:
  - `load`=1 → `q`←`data_in`; state stays IDLE.
  - `load`=1 and `start`=1 together → load wins; start is dropped.
  - `start`=1 with `load`=0 → latch `dir`, `mode`, `amount` internally.
    - If `amount`≠0, go to SHIFT with count=`amount`.
    - If `amount`=0, go to DONE and leave `q` unchanged.
- SHIFT: each edge applies one single-bit step to `q` and decrements count. When the count is 1 at the edge, go to DONE. `load`, `start` and changes to `dir`/`mode`/`amount` are ignored.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. `load`/`start` are ignored in DONE.
- Step rules, right (`dir`=0):
  - rotate: q[WIDTH-1]←q[0]
  - logical: q[WIDTH-1]←0
  - arithmetic: q[WIDTH-1]←q[WIDTH-1]
- Step rules, left (`dir`=1):
  - rotate: q[0]←q[WIDTH-1]
  - logical and arithmetic: q[0]←0
- Next-state selection per bit:
  - Level 1: `mux2to1`(s=dir) picks the right neighbour or left neighbour.
  - Level 2: `mux2to1`(s=load_en) picks between level 1 and `data_in`.
  - The hold path is a third mux level gated by the controller enable.

## Timing
- All outputs come directly from flops or state decode; there are no combinational paths from input to output.
- `load` sampled at edge k → `q`=`data_in` visible after edge k.
- `start` sampled at edge k with `amount`=N>0:
  - `busy`=1 after edge k.
  - `q` changes after edges k+1..k+N.
  - `busy`=0 and `done`=1 after edge k+N.
  - IDLE after edge k+N+1.
- `start` with `amount`=0 → `done`=1 after edge k, `busy` never rises.
- Total start-to-next-accept latency is N+2 edges. Back-to-back `start` is accepted on the first IDLE cycle after `done`.

## Test plan
- Reset, then load 0xA5; start rotate right, `amount`=3 → `busy` for 3 cycles, `q`=0xB4, one `done` pulse.
- Load 0x81; rotate left, `amount`=1 → `q`=0x03 after 2 edges, `done` pulse on the same cycle `busy` drops.
- Load 0x90; arithmetic right by 2 → `q`=0xE4. Repeat with logical right by 2 → `q`=0x24.
- Load 0xFF; logical left by 7 → `q`=0x80. Then `amount`=0 start → `q` stays 0x80, `done` one edge after start, `busy` stays 0.
- Raise `load`=1 with `data_in`=0x3C and `start`=1 together → `q`=0x3C, no `busy`. Assert `load`=0x11 during SHIFT → ignored, and the result matches the unloaded shift.
- Load 0xF0; start rotate right by 5, assert `reset` after 2 shift edges → next cycle `q`=0x00, `busy`=0, `done`=0, IDLE. A subsequent load is accepted immediately.
